// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory
// and registers the returned word into the IF/ID pipeline register.
module if_fetch_unit #(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] adressIM,
    input  logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_id,
    output logic [ADDR_W-1:0] pc_next_id,
    output logic              valid_id,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_halt;

    assign pc_inc   = pc + ADDR_W'(1);
    assign is_halt  = (inst == HALT_WORD);
    assign adressIM = pc;
    assign halted   = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst_id    <= '0;
            pc_next_id <= '0;
            valid_id   <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    pc       <= '0;
                    valid_id <= 1'b0;
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    // redirect kills the in-flight fetch even when stalled
                    if (redirect) begin
                        pc       <= redirect_addr;
                        valid_id <= 1'b0;
                    end else if (!stall) begin
                        inst_id    <= inst;
                        pc_next_id <= pc_inc;
                        valid_id   <= 1'b1;
                        fetch_cnt  <= fetch_cnt + CNT_W'(1);
                        if (is_halt) state <= S_HALTED;
                        else         pc    <= pc_inc;
                    end
                end
                S_HALTED: begin
                    valid_id <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    valid_id <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios plus random traffic
// checked against a behavioural fetch model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [4:0]  redirect_addr;
    logic [4:0]  adressIM;
    logic [31:0] inst;
    logic [31:0] inst_id;
    logic [4:0]  pc_next_id;
    logic        valid_id;
    logic        halted;
    logic [15:0] fetch_cnt;

    logic [31:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: 0 idle, 1 fetching, 2 halted
    int          m_state;
    int          m_pc;
    logic [31:0] m_inst;
    int          m_pcn;
    logic        m_valid;
    int          m_cnt;

    if_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .adressIM      (adressIM),
        .inst          (inst),
        .inst_id       (inst_id),
        .pc_next_id    (pc_next_id),
        .valid_id      (valid_id),
        .halted        (halted),
        .fetch_cnt     (fetch_cnt)
    );

    assign inst = mem[adressIM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_inst  = '0;
        m_pcn   = 0;
        m_valid = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge(input logic st, input logic sl,
                              input logic rd, input int ra);
        logic [31:0] w;
        if (m_state == 0) begin
            m_pc    = 0;
            m_valid = 1'b0;
            if (st) m_state = 1;
        end else if (m_state == 1) begin
            if (rd) begin
                m_pc    = ra;
                m_valid = 1'b0;
            end else if (!sl) begin
                w       = mem[m_pc];
                m_inst  = w;
                m_pcn   = (m_pc + 1) % 32;
                m_valid = 1'b1;
                m_cnt   = (m_cnt + 1) % 65536;
                if (w == 32'hFFFF_FFFF) m_state = 2;
                else m_pc = (m_pc + 1) % 32;
            end
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        n_tests++;
        assert (adressIM === 5'(m_pc)) else begin
            n_fail++;
            $error("FAIL %s adressIM got %0d exp %0d", tag, adressIM, m_pc);
        end
        n_tests++;
        assert (valid_id === m_valid) else begin
            n_fail++;
            $error("FAIL %s valid_id got %b exp %b", tag, valid_id, m_valid);
        end
        n_tests++;
        assert (inst_id === m_inst) else begin
            n_fail++;
            $error("FAIL %s inst_id got %h exp %h", tag, inst_id, m_inst);
        end
        n_tests++;
        assert (pc_next_id === 5'(m_pcn)) else begin
            n_fail++;
            $error("FAIL %s pc_next_id got %0d exp %0d", tag, pc_next_id, m_pcn);
        end
        n_tests++;
        assert (halted === (m_state == 2)) else begin
            n_fail++;
            $error("FAIL %s halted got %b exp %b", tag, halted, m_state == 2);
        end
        n_tests++;
        assert (fetch_cnt === 16'(m_cnt)) else begin
            n_fail++;
            $error("FAIL %s fetch_cnt got %0d exp %0d", tag, fetch_cnt, m_cnt);
        end
    endtask

    // inputs applied mid-cycle, outputs sampled on the falling edge
    task automatic step(input string tag, input logic st, input logic sl,
                        input logic rd, input int ra);
        start         = st;
        stall         = sl;
        redirect      = rd;
        redirect_addr = 5'(ra);
        @(posedge clk);
        model_edge(st, sl, rd, ra);
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check(tag);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic run_to(input string tag, input int target);
        int guard = 0;
        while (m_pc != target && guard < 100) begin
            step(tag, 1'b0, 1'b0, 1'b0, 0);
            guard++;
        end
        n_tests++;
        assert (guard < 100) else begin
            n_fail++;
            $error("FAIL %s timeout pc got %0d exp %0d", tag, m_pc, target);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_addr = '0;
        for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + k;
        model_reset();
        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < 6; i++)
            step("idle", 1'b0, i[0], i[1], 7 + i);

        step("start", 1'b1, 1'b0, 1'b0, 0);
        run_to("seq", 4);
        step("stall1", 1'b1, 1'b1, 1'b0, 0);
        step("stall2", 1'b0, 1'b1, 1'b0, 0);
        step("stall3", 1'b0, 1'b1, 1'b0, 0);
        run_to("seq2", 6);
        step("redir", 1'b0, 1'b1, 1'b1, 20);
        step("redir_fetch", 1'b0, 1'b0, 1'b0, 0);
        run_to("wrap", 0);
        mem[9] = 32'hFFFF_FFFF;
        run_to("to_halt", 9);
        step("halt", 1'b0, 1'b0, 1'b0, 0);
        step("halted_redir", 1'b1, 1'b0, 1'b1, 0);
        step("halted_hold", 1'b0, 1'b1, 1'b0, 3);
        step("halted_hold2", 1'b0, 1'b0, 1'b0, 0);

        @(negedge clk);
        do_reset("reset_halt");
        mem[9] = 32'h1000_0009;
        step("start2", 1'b1, 1'b0, 1'b0, 0);
        run_to("seq3", 13);
        #2;
        do_reset("reset_mid");
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            step("post_reset_idle", 1'b0, i[0], 1'b0, 0);

        for (int k = 0; k < 32; k++)
            mem[k] = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) begin
                do_reset("rand_reset");
                @(negedge clk);
            end else begin
                step("rand", $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 31)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
